// File: rtl/hazard_pkg.sv
// Shared opcode constants, multiplier FSM state type and source-usage helpers.
// Used by hazard_ctrl and mul_stall_fsm.
package hazard_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_RTYPE || op == OP_STORE || op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/mul_stall_fsm.sv
// Multiplier occupancy tracker: holds EX for MUL_LATENCY-1 cycles per MUL.
// Outputs combinational from state/cnt/ex_is_mul; all outputs forced low in reset.
module mul_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_is_mul,
  output logic mul_start,
  output logic mul_stall
);

  // First stall cycle is spent in IDLE, so BUSY counts the remaining L-2.
  localparam logic [3:0] CNT_INIT = (MUL_LATENCY > 1) ? 4'(MUL_LATENCY - 2) : 4'd0;

  mul_state_e state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mul_start = 1'b0;
    mul_stall = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (ex_is_mul) begin
            mul_start = 1'b1;
            if (MUL_LATENCY > 1) begin
              mul_stall = 1'b1;
              state_nxt = BUSY;
              cnt_nxt   = CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            mul_stall = 1'b1;
            cnt_nxt   = cnt - 4'd1;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID/EX hazard control: load-use bubble, branch flush, multiplier hold; combinational outputs.
// Optional HAZARD_PERF_CNT_EN adds stall/mul/flush cycle counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_inst,
  input  logic [31:0] ex_inst,
  input  logic        ex_jb_taken,
  output logic        stall,
  output logic        jb,
  output logic        mul_stall,
  output logic        mul_start,
  output logic        pc_en,
  output logic        id_en
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_cycles,
  output logic [31:0] perf_mul_cycles,
  output logic [31:0] perf_flushes
`endif
);

  logic       ex_is_load;
  logic       ex_is_mul;
  logic [4:0] ex_rd;
  logic [6:0] id_op;
  logic       lu;
  logic       unused_bits;

  assign ex_is_load = (ex_inst[6:0] == OP_LOAD);
  assign ex_is_mul  = (ex_inst[6:0] == OP_RTYPE) && (ex_inst[31:25] == FUNCT7_MULDIV);
  assign ex_rd      = ex_inst[11:7];
  assign id_op      = id_inst[6:0];

  assign lu = ex_is_load && (ex_rd != 5'd0) &&
              ((uses_rs1(id_op) && id_inst[19:15] == ex_rd) ||
               (uses_rs2(id_op) && id_inst[24:20] == ex_rd));

  assign unused_bits = ^{id_inst[31:25], id_inst[14:7], ex_inst[24:12]};

  mul_stall_fsm #(
    .MUL_LATENCY(MUL_LATENCY)
  ) u_mul_fsm (
    .clk       (clk),
    .rst       (rst),
    .ex_is_mul (ex_is_mul),
    .mul_start (mul_start),
    .mul_stall (mul_stall)
  );

  // A taken branch under a MUL hold is a protocol error and is dropped.
  assign jb    = !rst && ex_jb_taken && !mul_stall;
  assign stall = !rst && lu && !jb && !mul_stall;
  assign pc_en = !rst && (jb || !(stall || mul_stall));
  assign id_en = pc_en;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_cycles  <= 32'd0;
      perf_mul_cycles <= 32'd0;
      perf_flushes    <= 32'd0;
    end else begin
      if (stall)     perf_lu_cycles  <= perf_lu_cycles + 32'd1;
      if (mul_stall) perf_mul_cycles <= perf_mul_cycles + 32'd1;
      if (jb)        perf_flushes    <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench with expected-response queue and decoupled negedge monitor.
module tb_hazard_ctrl;

  localparam logic [31:0] LW5      = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] LW0      = 32'h0000A003; // lw x0,0(x1)
  localparam logic [31:0] ADD_HAZ  = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] ADD_X0   = 32'h00200333; // add x6,x0,x2
  localparam logic [31:0] ADD_RS2  = 32'h00508333; // add x6,x1,x5
  localparam logic [31:0] ADDI_IMM = 32'h00538313; // addi x6,x7,5
  localparam logic [31:0] ADDI_X5  = 32'h00128313; // addi x6,x5,1
  localparam logic [31:0] LUI_X6   = 32'h00028337; // lui x6,0x28 (bits[19:15]=5)
  localparam logic [31:0] SW_X5    = 32'h00512023; // sw x5,0(x2)
  localparam logic [31:0] MUL      = 32'h022081B3; // mul x3,x1,x2

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_inst, ex_inst;
  logic        ex_jb_taken;
  logic        stall, jb, mul_stall, mul_start, pc_en, id_en;
  logic        s1_stall, s1_jb, s1_mul_stall, s1_mul_start, s1_pc_en, s1_id_en;

  int n_vec = 0;
  int n_bad = 0;
  int vec_id = 0;

  typedef struct {
    int         idx;
    logic [7:0] bits;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_cycles, perf_mul_cycles, perf_flushes;
  logic [31:0] p1_lu, p1_mul, p1_fl;
`endif

  hazard_ctrl #(.MUL_LATENCY(4)) dut (
    .clk(clk), .rst(rst), .id_inst(id_inst), .ex_inst(ex_inst), .ex_jb_taken(ex_jb_taken),
    .stall(stall), .jb(jb), .mul_stall(mul_stall), .mul_start(mul_start),
    .pc_en(pc_en), .id_en(id_en)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_lu_cycles(perf_lu_cycles), .perf_mul_cycles(perf_mul_cycles),
    .perf_flushes(perf_flushes)
`endif
  );

  hazard_ctrl #(.MUL_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .id_inst(id_inst), .ex_inst(ex_inst), .ex_jb_taken(ex_jb_taken),
    .stall(s1_stall), .jb(s1_jb), .mul_stall(s1_mul_stall), .mul_start(s1_mul_start),
    .pc_en(s1_pc_en), .id_en(s1_id_en)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_lu_cycles(p1_lu), .perf_mul_cycles(p1_mul), .perf_flushes(p1_fl)
`endif
  );

  // e = {stall, jb, mul_stall, mul_start, pc_en}; l1 = mul_start of the latency-1 build
  task automatic apply(input logic r, input logic [31:0] id, input logic [31:0] ex,
                       input logic jt, input logic [4:0] e, input logic l1);
    exp_t x;
    @(posedge clk);
    #1;
    rst         = r;
    id_inst     = id;
    ex_inst     = ex;
    ex_jb_taken = jt;
    x.idx  = vec_id;
    x.bits = {e[4:1], e[0], e[0], 1'b0, l1};
    exp_q.push_back(x);
    vec_id++;
  endtask

  initial begin : monitor
    exp_t       x;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x   = exp_q.pop_front();
        act = {stall, jb, mul_stall, mul_start, pc_en, id_en, s1_mul_stall, s1_mul_start};
        n_vec++;
        if (act !== x.bits) begin
          n_bad++;
          $display("FAIL vec%0d {stall,jb,mst,mstart,pc_en,id_en,l1_mst,l1_mstart} got %b want %b",
                   x.idx, act, x.bits);
        end
      end
    end
  end

  initial begin : driver
    int wait_cyc;
    rst = 1'b1; id_inst = '0; ex_inst = '0; ex_jb_taken = 1'b0;
    // reset: all outputs low even with hazards on the inputs
    apply(1, ADD_HAZ, MUL, 1, 5'b00000, 0);
    apply(1, ADD_HAZ, LW5, 1, 5'b00000, 0);
    apply(0, '0,       '0,  0, 5'b00001, 0);
    // load-use decode
    apply(0, ADD_HAZ,  LW5, 0, 5'b10000, 0);
    apply(0, ADD_X0,   LW0, 0, 5'b00001, 0);
    apply(0, ADDI_IMM, LW5, 0, 5'b00001, 0);
    apply(0, ADDI_X5,  LW5, 0, 5'b10000, 0);
    apply(0, ADD_RS2,  LW5, 0, 5'b10000, 0);
    apply(0, LUI_X6,   LW5, 0, 5'b00001, 0);
    apply(0, SW_X5,    LW5, 0, 5'b10000, 0);
    // flush beats load-use
    apply(0, ADD_HAZ,  LW5, 1, 5'b01001, 0);
    apply(0, '0,       '0,  1, 5'b01001, 0);
    // MUL occupancy, taken branch under hold ignored, back-to-back MUL
    apply(0, ADD_HAZ, MUL, 0, 5'b00110, 1);
    apply(0, '0,      MUL, 0, 5'b00100, 1);
    apply(0, '0,      MUL, 1, 5'b00100, 1);
    apply(0, '0,      MUL, 0, 5'b00001, 1);
    apply(0, '0,      MUL, 0, 5'b00110, 1);
    apply(0, '0,      MUL, 0, 5'b00100, 1);
    apply(0, '0,      MUL, 0, 5'b00100, 1);
    apply(0, '0,      MUL, 0, 5'b00001, 1);
    apply(0, ADD_HAZ, LW5, 0, 5'b10000, 0);
    // reset in the middle of a MUL hold
    apply(0, '0, MUL, 0, 5'b00110, 1);
    apply(0, '0, MUL, 0, 5'b00100, 1);
    apply(1, '0, MUL, 0, 5'b00000, 0);
    apply(0, '0, '0,  0, 5'b00001, 0);
`ifdef HAZARD_PERF_CNT_EN
    #1;
    n_vec++;
    if ({perf_lu_cycles, perf_mul_cycles, perf_flushes} !== 96'd0) begin
      n_bad++;
      $display("FAIL perf_after_reset got %h %h %h want 0 0 0",
               perf_lu_cycles, perf_mul_cycles, perf_flushes);
    end
`endif
    apply(0, '0,      MUL, 0, 5'b00110, 1);
    apply(0, '0,      '0,  0, 5'b00100, 0);
    apply(0, '0,      '0,  0, 5'b00100, 0);
    apply(0, '0,      '0,  0, 5'b00001, 0);
    apply(0, ADD_HAZ, LW5, 0, 5'b10000, 0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
